// File: rtl/slv_model_px.sv
// Self-checking bus slave model: ready strobe WAIT+1 cycles after sel is sampled, minimum period WAIT+2.
// A master stalls by holding sel; dropping sel before the ACK commit aborts the transaction with code 3.
module slv_model_px #(
    parameter int            DW       = 32,
    parameter int            AW       = 32,
    parameter int            DEPTH    = 4,
    parameter int            IDX_LSB  = 4,
    parameter logic [AW-1:0] BASE     = AW'(32'hFFEF_0200),
    parameter logic [AW-1:0] MASK     = AW'(32'hFFEF_FF00),
    parameter int            ID_SHIFT = 12,
    parameter int            WAIT     = 0,
    parameter int            CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id,
    input  logic             sel,
    input  logic             rw,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    data_to_slave,
    output logic [DW-1:0]    data_from_slave,
    output logic             ready,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count
);

    localparam int         IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_L = 4'(WAIT);

    typedef enum logic [1:0] {IDLE, WAITS, ACK} state_t;

    state_t          state, state_nxt;
    logic [3:0]      wcnt, wcnt_nxt;
    logic            rw_q, hit_q;
    logic [IW-1:0]   idx_q;
    logic            accept, commit, abort;

    logic [DW-1:0]   wexp [DEPTH];
    logic [DW-1:0]   rdat [DEPTH];

    logic [AW-1:0]   saddr;
    logic            hit_now;
    logic [IW-1:0]   idx_now;

    logic            err_set, wr_ok, rd_ok, wexp_bump, rdat_bump;
    logic [1:0]      code_nxt;

    assign saddr   = BASE | (AW'(id) << ID_SHIFT);
    assign hit_now = ((addr & MASK) == saddr);
    assign idx_now = addr[IDX_LSB +: IW];

    assign data_from_slave = (sel && hit_now) ? rdat[idx_now] : '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        accept    = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (sel) begin
                    accept    = 1'b1;
                    wcnt_nxt  = WAIT_L;
                    state_nxt = (WAIT > 0) ? WAITS : ACK;
                end
            end
            WAITS: begin
                if (!sel) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (wcnt == 4'd1) begin
                    state_nxt = ACK;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
                if (sel) commit = 1'b1;
                else     abort  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outcome of the edge ending ACK (or of an abort); write compare uses data_to_slave as seen at that edge.
    always_comb begin
        err_set   = 1'b0;
        code_nxt  = err_code;
        wr_ok     = 1'b0;
        rd_ok     = 1'b0;
        wexp_bump = 1'b0;
        rdat_bump = 1'b0;
        if (abort) begin
            err_set  = 1'b1;
            code_nxt = 2'd3;
        end else if (commit) begin
            if (!hit_q) begin
                err_set  = 1'b1;
                code_nxt = 2'd1;
            end else if (rw_q) begin
                wexp_bump = 1'b1;
                if (data_to_slave == wexp[idx_q]) begin
                    wr_ok = 1'b1;
                end else begin
                    err_set  = 1'b1;
                    code_nxt = 2'd2;
                end
            end else begin
                rdat_bump = 1'b1;
                rd_ok     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            rw_q      <= 1'b0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            err_count <= '0;
            wr_count  <= '0;
            rd_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wexp[i] <= DW'(id) << (DW - 4);
                rdat[i] <= DW'(id) << (DW - 8);
            end
        end else begin
            state    <= state_nxt;
            wcnt     <= wcnt_nxt;
            ready    <= (state_nxt == ACK);
            err      <= err_set;
            err_code <= code_nxt;
            if (accept) begin
                rw_q  <= rw;
                hit_q <= hit_now;
                idx_q <= idx_now;
            end
            if (err_set)   err_count   <= sat_inc(err_count);
            if (wr_ok)     wr_count    <= sat_inc(wr_count);
            if (rd_ok)     rd_count    <= sat_inc(rd_count);
            if (wexp_bump) wexp[idx_q] <= wexp[idx_q] + DW'(1);
            if (rdat_bump) rdat[idx_q] <= rdat[idx_q] + DW'(1);
        end
    end

endmodule
